// File: rtl/led_step_counter.sv
// LED step counter: a single-clock prescaler acts as a clock enable, and a
// WIDTH-bit counter steps once per prescaler expiry. There are four modes:
// up-wrap, down-wrap, up-saturate and bounce. Synchronous clr and load
// both restart the prescaler. tick and term are registered one-cycle pulses
// that line up with the cycle in which the new count becomes visible.
module led_step_counter #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50_000_000,
    parameter int MAX   = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             term,
    output logic             dir
);

    // The prescaler is at least one bit wide, so DIV=1 still has a register.
    // That register stays at 0, so every enabled edge is an expiry.
    localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'b00,
        MODE_DOWN_WRAP = 2'b01,
        MODE_UP_SAT    = 2'b10,
        MODE_BOUNCE    = 2'b11
    } mode_e;

    logic [PW-1:0]    pre;
    logic             expire;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_count;
    logic             step_dir;
    logic             step_term;

    // Expiry is only meaningful when enabled. Dropping en on the expiry edge
    // leaves the prescaler parked at DIV-1 until en returns.
    always_comb begin
        expire = en && (pre == PRE_LAST);
    end

    // Clamp load values above the terminal count so count stays in 0..MAX.
    always_comb begin
        load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    end

    // Next count, direction and terminal flag if this edge is a step.
    always_comb begin
        step_count = count;
        step_dir   = dir;
        step_term  = 1'b0;
        case (mode_e'(mode))
            MODE_UP_WRAP: begin
                step_dir = 1'b1;
                if (count == MAX_V) begin
                    step_count = '0;
                    step_term  = 1'b1;
                end else begin
                    step_count = count + WIDTH'(1);
                end
            end
            MODE_DOWN_WRAP: begin
                step_dir = 1'b0;
                if (count == '0) begin
                    step_count = MAX_V;
                    step_term  = 1'b1;
                end else begin
                    step_count = count - WIDTH'(1);
                end
            end
            MODE_UP_SAT: begin
                step_dir = 1'b1;
                // Once parked at MAX, the count holds and term stays low.
                if (count != MAX_V) begin
                    step_count = count + WIDTH'(1);
                    step_term  = (count == MAX_V - WIDTH'(1));
                end
            end
            MODE_BOUNCE: begin
                // The direction is inherited from whatever mode ran before.
                if (dir) begin
                    if (count == MAX_V) begin
                        step_count = MAX_V - WIDTH'(1);
                        step_dir   = 1'b0;
                        step_term  = 1'b1;
                    end else begin
                        step_count = count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        step_count = WIDTH'(1);
                        step_dir   = 1'b1;
                        step_term  = 1'b1;
                    end else begin
                        step_count = count - WIDTH'(1);
                    end
                end
            end
            default: begin
                step_count = count;
            end
        endcase
    end

    // Prescaler, count, direction and pulse registers.
    // Priority order is reset, then clr, then load, then step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre   <= '0;
            count <= '0;
            dir   <= 1'b1;
            tick  <= 1'b0;
            term  <= 1'b0;
        end else if (clr) begin
            pre   <= '0;
            count <= '0;
            dir   <= 1'b1;
            tick  <= 1'b0;
            term  <= 1'b0;
        end else if (load) begin
            pre   <= '0;
            count <= load_clamped;
            tick  <= 1'b0;
            term  <= 1'b0;
        end else if (expire) begin
            pre   <= '0;
            count <= step_count;
            dir   <= step_dir;
            tick  <= 1'b1;
            term  <= step_term;
        end else begin
            if (en) begin
                pre <= pre + PW'(1);
            end
            tick <= 1'b0;
            term <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_step_counter.sv
// Bench for led_step_counter with WIDTH=4, DIV=4, MAX=9.
// It runs a vector table of hand-derived expectations, then hand-written
// sequences for async reset, then randomized traffic. A behavioural model
// runs alongside and checks every edge.
module tb_led_step_counter;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int MAX   = 9;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             term;
    logic             dir;

    led_step_counter #(
        .WIDTH(WIDTH),
        .DIV  (DIV),
        .MAX  (MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .tick    (tick),
        .term    (term),
        .dir     (dir)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required run to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model tracks the count, the number of enabled edges since the
    // prescaler last restarted, and the direction. All of it is plain
    // integer arithmetic.
    int m_count;
    int m_phase;
    bit m_dir;
    bit m_tick;
    bit m_term;
    logic [6:0] exp_q[$];

    task automatic model_reset();
        m_count = 0;
        m_phase = 0;
        m_dir   = 1'b1;
        m_tick  = 1'b0;
        m_term  = 1'b0;
    endtask

    task automatic model_edge(input bit e, input int m, input bit c, input bit l, input int lv);
        m_tick = 1'b0;
        m_term = 1'b0;
        if (c) begin
            m_count = 0;
            m_phase = 0;
            m_dir   = 1'b1;
        end else if (l) begin
            m_count = (lv > MAX) ? MAX : lv;
            m_phase = 0;
        end else if (e) begin
            m_phase++;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_tick  = 1'b1;
                case (m)
                    0: begin
                        m_dir = 1'b1;
                        if (m_count == MAX) begin m_count = 0; m_term = 1'b1; end
                        else m_count++;
                    end
                    1: begin
                        m_dir = 1'b0;
                        if (m_count == 0) begin m_count = MAX; m_term = 1'b1; end
                        else m_count--;
                    end
                    2: begin
                        m_dir = 1'b1;
                        if (m_count < MAX) begin
                            m_count++;
                            m_term = (m_count == MAX);
                        end
                    end
                    default: begin
                        if (m_dir && m_count == MAX) begin
                            m_count = MAX - 1; m_dir = 1'b0; m_term = 1'b1;
                        end else if (!m_dir && m_count == 0) begin
                            m_count = 1; m_dir = 1'b1; m_term = 1'b1;
                        end else if (m_dir) begin
                            m_count++;
                        end else begin
                            m_count--;
                        end
                    end
                endcase
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drive one edge's inputs, update the model at the edge, then compare
    // 1 ns after the edge.
    task automatic apply(input bit e, input logic [1:0] m, input bit c, input bit l,
                         input logic [3:0] lv);
        logic [6:0] exp_v;
        en = e; mode = m; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge(e, int'(m), c, l, int'(lv));
        exp_q.push_back({m_dir, m_term, m_tick, 4'(m_count)});
        #1;
        exp_v = exp_q.pop_front();
        check("model_count", int'(count), int'(exp_v[3:0]));
        check("model_tick",  int'(tick),  int'(exp_v[4]));
        check("model_term",  int'(term),  int'(exp_v[5]));
        check("model_dir",   int'(dir),   int'(exp_v[6]));
    endtask

    // ---------------- vector table ----------------
    // Each row holds its inputs for n edges. clr and load are applied on
    // the first edge only. The outputs are then compared after the last edge.
    typedef struct {
        bit         en;
        logic [1:0] mode;
        bit         clr;
        bit         load;
        logic [3:0] lv;
        int         n;
        int         e_count;
        int         e_tick;
        int         e_term;
        int         e_dir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit e, input logic [1:0] m, input bit c, input bit l,
                       input logic [3:0] lv, input int n,
                       input int ec, input int etk, input int etm, input int ed);
        vec_t v;
        v.en = e; v.mode = m; v.clr = c; v.load = l; v.lv = lv; v.n = n;
        v.e_count = ec; v.e_tick = etk; v.e_term = etm; v.e_dir = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // Up-wrap from reset: one step per 4 edges, then 9 wraps to 0 with term.
        add(1, 2'd0, 0, 0, 4'd0,  3, 0, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  1, 1, 1, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  1, 1, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0, 31, 9, 1, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  4, 0, 1, 1, 1);
        add(1, 2'd0, 0, 0, 4'd0,  1, 0, 0, 0, 1);
        // clr, then down-wrap: 0 goes to 9 with term, then 8 without term.
        add(1, 2'd1, 1, 0, 4'd0,  1, 0, 0, 0, 1);
        add(1, 2'd1, 0, 0, 4'd0,  4, 9, 1, 1, 0);
        add(1, 2'd1, 0, 0, 4'd0,  4, 8, 1, 0, 0);
        // Up-saturate from 7: 8, then 9 with term, then 9 held.
        add(1, 2'd2, 0, 1, 4'd7,  1, 7, 0, 0, 0);
        add(1, 2'd2, 0, 0, 4'd0,  4, 8, 1, 0, 1);
        add(1, 2'd2, 0, 0, 4'd0,  4, 9, 1, 1, 1);
        add(1, 2'd2, 0, 0, 4'd0,  4, 9, 1, 0, 1);
        add(1, 2'd2, 0, 0, 4'd0,  4, 9, 1, 0, 1);
        // Bounce from 8 going up: 9, 8 (term, down), 7..0, 1 (term, up).
        add(1, 2'd3, 0, 1, 4'd8,  1, 8, 0, 0, 1);
        add(1, 2'd3, 0, 0, 4'd0,  4, 9, 1, 0, 1);
        add(1, 2'd3, 0, 0, 4'd0,  4, 8, 1, 1, 0);
        add(1, 2'd3, 0, 0, 4'd0,  4, 7, 1, 0, 0);
        add(1, 2'd3, 0, 0, 4'd0, 28, 0, 1, 0, 0);
        add(1, 2'd3, 0, 0, 4'd0,  4, 1, 1, 1, 1);
        add(1, 2'd3, 0, 0, 4'd0,  4, 2, 1, 0, 1);
        // A load of 15 clamps to 9. A load on an expiry edge suppresses the step.
        add(1, 2'd0, 0, 1, 4'd15, 1, 9, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  3, 9, 0, 0, 1);
        add(1, 2'd0, 0, 1, 4'd15, 1, 9, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  3, 9, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  1, 0, 1, 1, 1);
        // en low across the expiry edge: everything holds, then the step fires at once.
        add(1, 2'd0, 0, 0, 4'd0,  3, 0, 0, 0, 1);
        add(0, 2'd0, 0, 0, 4'd0, 10, 0, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  1, 1, 1, 0, 1);
        // clr on an expiry edge wins, and the prescaler restarts.
        add(1, 2'd0, 0, 0, 4'd0,  3, 1, 0, 0, 1);
        add(1, 2'd0, 1, 0, 4'd0,  1, 0, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  3, 0, 0, 0, 1);
        add(1, 2'd0, 0, 0, 4'd0,  1, 1, 1, 0, 1);
    end

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'd0; clr = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #3;
        check("reset_count", int'(count), 0);
        check("reset_tick",  int'(tick),  0);
        check("reset_term",  int'(term),  0);
        check("reset_dir",   int'(dir),   1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                apply(vecs[i].en, vecs[i].mode,
                      (k == 0) ? vecs[i].clr : 1'b0,
                      (k == 0) ? vecs[i].load : 1'b0,
                      vecs[i].lv);
            end
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
            check($sformatf("vec%0d_tick", i),  int'(tick),  vecs[i].e_tick);
            check($sformatf("vec%0d_term", i),  int'(term),  vecs[i].e_term);
            check($sformatf("vec%0d_dir", i),   int'(dir),   vecs[i].e_dir);
        end

        // Async reset between edges while count=5 with tick high and dir=0.
        apply(1, 2'd1, 0, 1, 4'd6);
        for (int k = 0; k < 4; k++) apply(1, 2'd1, 0, 0, 4'd0);
        check("pre_rst_count", int'(count), 5);
        check("pre_rst_tick",  int'(tick),  1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_dir",   int'(dir),   1);
        check("async_rst_tick",  int'(tick),  0);
        check("async_rst_term",  int'(term),  0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) apply(1, 2'd0, 0, 0, 4'd0);
        check("post_rst_no_tick", int'(tick), 0);
        apply(1, 2'd0, 0, 0, 4'd0);
        check("post_rst_tick",  int'(tick),  1);
        check("post_rst_count", int'(count), 1);

        // Randomized traffic checked against the model.
        begin
            logic [1:0] m;
            m = 2'd0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 7) == 0) m = 2'($urandom_range(0, 3));
                apply($urandom_range(0, 9) != 0, m,
                      $urandom_range(0, 39) == 0,
                      $urandom_range(0, 29) == 0,
                      4'($urandom_range(0, 15)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_step_counter.md
# led_step_counter

Parametrised LED step counter: a single-clock prescaler produces a tick every DIV cycles, and a WIDTH-bit counter advances once per tick in one of four modes: up-wrap, down-wrap, up-saturate or bounce. It replaces derived-clock divider/counter pairs in the board LED path. Everything runs on `clk`, with the prescaler acting as a clock enable. It adds synchronous load/clear, a programmable terminal count, and tick, terminal and direction status outputs.

## Interface
- WIDTH, 4: counter width in bits.
- DIV, 50_000_000: `clk` cycles per tick; legal range ≥1.
- MAX, 2**WIDTH-1: terminal count, so the count range is 0..MAX; legal range 1..2**WIDTH-1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  enables prescaler and counting.
- mode  in  2  selects the counting mode: 00 up-wrap, 01 down-wrap, 10 up-saturate, 11 bounce.
- clr  in  1  synchronous clear of count, prescaler and direction.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  load value; values above MAX are clamped to MAX.
- count  out  WIDTH  current count.
- tick  out  1  one-cycle pulse on each counter step.
- term  out  1  one-cycle pulse on a terminal event.
- dir  out  1  direction register; 1 = up.

## Operation
- Prescaler width is clog2(DIV), minimum 1 bit. It counts 0..DIV-1 while en=1 and holds while en=0.
- A step occurs on the edge where en=1 and prescaler==DIV-1. On that edge the prescaler returns to 0.
- Priority per edge, highest first: reset, clr, load, step.
  - clr: count=0, prescaler=0, dir=1. No tick or term pulse.
  - load: count=min(load_val,MAX), prescaler=0, dir unchanged. No tick or term pulse.
  - clr and load operate regardless of en.
- Step rules by mode:
  - 00 (up-wrap): MAX→0 with term=1; otherwise +1. dir set to 1.
  - 01 (down-wrap): 0→MAX with term=1; otherwise -1. dir set to 0.
  - 10 (up-saturate): +1 until MAX. term=1 on the step that reaches MAX. At MAX, count holds and term=0; tick still pulses. dir set to 1.
  - 11 (bounce), dir=1: at MAX, count→MAX-1, dir→0, term=1; otherwise +1.
  - 11 (bounce), dir=0: at 0, count→1, dir→1, term=1; otherwise -1.
  - Entering bounce from another mode keeps the current dir.
- Mode changes take effect at the next step. The prescaler phase is unaffected.
- count never leaves 0..MAX, because load clamps and all step arithmetic is bounded.
- DIV=1: every cycle with en=1 is a step.

## Timing
- Reset values, applied immediately on reset assertion without a clock edge:
  - count=0, prescaler=0, dir=1, tick=0, term=0.
- tick and term are registered. They assert for exactly one cycle, in the same cycle the new count value is visible.
- With en held at 1 from reset release, the first step lands on the DIV-th rising edge. Subsequent steps occur every DIV edges.
- load and clr have 1-edge latency. After either, the next step occurs DIV enabled edges later.
- Load or clr on the same edge as a prescaler expiry: load/clr wins. No step, no tick, and the prescaler restarts from 0.
- Dropping en on an expiry edge suppresses that step. The prescaler keeps its value (DIV-1) and the step fires on the first edge that has en=1 again.
- Reset asserted mid-run clears all state. Counting resumes DIV edges after release.

## Test plan
All scenarios use WIDTH=4, DIV=4, MAX=9.
1. Reset release, en=1, mode=00 → count increments every 4 edges with one tick each. After 10 steps, count goes 9→0 with term=1 in that cycle only.
2. clr, then mode=01 → first step gives count=9 with term=1; the next step gives 8 with term=0. dir=0.
3. mode=10, load 7 → steps give 8, then 9 (term=1), then 9 (term=0, tick=1) on every further step.
4. mode=11, load 8 with dir=1 → step sequence 9, 8 (term, dir=0), 7 … 0, then 1 (term, dir=1).
5. load_val=15 → count=9. Assert load on an expiry edge → tick=0, count=9, and the next tick follows exactly 4 edges later. en=0 for 10 cycles → no tick; count and prescaler hold.
6. Assert reset asynchronously between edges while count=5 → count=0, dir=1, tick=0, term=0 before the next edge. After release, the first step occurs on the 4th edge.
